// File: rtl/pipe_pkg.sv
// Shared pipeline types: control bundle layout, bubble value,
// occupancy state encoding and a state-to-count helper.
package pipe_pkg;

    localparam int CTRL_W = 8;

    typedef struct packed {
        logic       wbs;
        logic       wme;
        logic       mm;
        logic [1:0] aluop;
        logic       wm;
        logic       am;
        logic       ni;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    function automatic logic [1:0] occ_of(input state_e s);
        logic [1:0] n;
        n = 2'd0;
        unique case (s)
            EMPTY:   n = 2'd0;
            ONE:     n = 2'd1;
            FULL:    n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable; async active-low reset.
// Ports: clk, rst_n, en_i (count this cycle), cnt_o (value).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_stage_reg.sv
// Two-entry (main + skid) pipeline register with valid/ready
// handshake, synchronous flush and optional perf counters.
// Ports: clk, rst_n (async, active-low), flush;
//   upstream in_valid/in_ready/in_ctrl/in_data;
//   downstream out_valid/out_ready/out_ctrl/out_data;
//   occupancy (0..2); stall_cnt, flush_cnt.
// Macro PIPELINE_STAGE_PERF_EN builds the two counters;
// without it the counter outputs are tied to zero.
module pipeline_stage_reg
    import pipe_pkg::*;
#(
    parameter int                 CTRL_W   = 8,
    parameter int                 DATA_W   = 32,
    parameter logic [CTRL_W-1:0]  NOP_CTRL = {CTRL_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt
);

    state_e            state_q;
    state_e            state_d;
    logic              rdy_q;
    logic              rdy_d;
    logic              vld_q;
    logic              vld_d;
    logic [CTRL_W-1:0] main_ctrl_q;
    logic [CTRL_W-1:0] main_ctrl_d;
    logic [DATA_W-1:0] main_data_q;
    logic [DATA_W-1:0] main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic [CTRL_W-1:0] skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q;
    logic [DATA_W-1:0] skid_data_d;

    logic accept;
    logic retire;

    assign accept = in_valid && rdy_q;
    assign retire = vld_q && out_ready;

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            state_d     = EMPTY;
            main_ctrl_d = NOP_CTRL;
            main_data_d = '0;
            skid_ctrl_d = NOP_CTRL;
            skid_data_d = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                        state_d     = ONE;
                    end
                end
                ONE: begin
                    unique case (1'b1)
                        accept && !retire: begin
                            skid_ctrl_d = in_ctrl;
                            skid_data_d = in_data;
                            state_d     = FULL;
                        end
                        !accept && retire: begin
                            main_ctrl_d = NOP_CTRL;
                            main_data_d = '0;
                            state_d     = EMPTY;
                        end
                        accept && retire: begin
                            main_ctrl_d = in_ctrl;
                            main_data_d = in_data;
                        end
                        default: ;
                    endcase
                end
                FULL: begin
                    // in_ready is low here, so only a retire can occur
                    if (retire) begin
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        skid_ctrl_d = NOP_CTRL;
                        skid_data_d = '0;
                        state_d     = ONE;
                    end
                end
                default: begin
                    state_d     = EMPTY;
                    main_ctrl_d = NOP_CTRL;
                    main_data_d = '0;
                    skid_ctrl_d = NOP_CTRL;
                    skid_data_d = '0;
                end
            endcase
        end
        vld_d = (state_d != EMPTY);
        rdy_d = (state_d != FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            rdy_q       <= 1'b0;
            vld_q       <= 1'b0;
            main_ctrl_q <= NOP_CTRL;
            main_data_q <= '0;
            skid_ctrl_q <= NOP_CTRL;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= rdy_d;
            vld_q       <= vld_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = vld_q;
    assign out_ctrl  = main_ctrl_q;
    assign out_data  = main_data_q;
    assign occupancy = occ_of(state_q);

`ifdef PIPELINE_STAGE_PERF_EN
    logic stall_en;
    logic flush_en;

    assign stall_en = vld_q && !out_ready;
    assign flush_en = flush && (state_q != EMPTY);

    sat_counter #(
        .W (16)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (stall_en),
        .cnt_o (stall_cnt)
    );

    sat_counter #(
        .W (16)
    ) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (flush_en),
        .cnt_o (flush_cnt)
    );
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Scoreboard bench for pipeline_stage_reg: a queue model of the
// two-entry stage, directed scenarios plus a random phase.
module tb_pipeline_stage_reg;
    import pipe_pkg::*;

    typedef struct packed {
        logic [7:0]  c;
        logic [31:0] d;
    } ent_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_ctrl;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_ctrl;
    logic [31:0] out_data;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    ent_t sb[$];
    logic rdy_exp;
    int   nvec;
    int   nerr;

    pipeline_stage_reg #(
        .CTRL_W   (8),
        .DATA_W   (32),
        .NOP_CTRL (8'h00)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        check({tag, "_rdy"}, 64'(in_ready), 64'd0);
        check({tag, "_vld"}, 64'(out_valid), 64'd0);
        check({tag, "_ctrl"}, 64'(out_ctrl), 64'd0);
        check({tag, "_data"}, 64'(out_data), 64'd0);
        check({tag, "_occ"}, 64'(occupancy), 64'd0);
        check({tag, "_stall"}, 64'(stall_cnt), 64'd0);
        check({tag, "_flcnt"}, 64'(flush_cnt), 64'd0);
    endtask

    // Called just after a falling edge: drive, check, update model,
    // cross the rising edge, return at the next falling edge.
    task automatic step(input logic v, input logic [7:0] c,
                        input logic [31:0] d, input logic ordy,
                        input logic fl);
        ent_t e;
        logic mvld;
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        mvld = (sb.size() != 0);
        check("occ", 64'(occupancy), 64'(sb.size()));
        check("out_valid", 64'(out_valid), 64'(mvld));
        check("in_ready", 64'(in_ready), 64'(rdy_exp));
        if (!mvld) begin
            check("bubble_ctrl", 64'(out_ctrl), 64'd0);
            check("bubble_data", 64'(out_data), 64'd0);
        end
        if (fl) begin
            sb.delete();
        end else begin
            if (mvld && ordy) begin
                e = sb.pop_front();
                check("out_ctrl", 64'(out_ctrl), 64'(e.c));
                check("out_data", 64'(out_data), 64'(e.d));
            end
            if (v && rdy_exp) begin
                e.c = c;
                e.d = d;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        rdy_exp = (sb.size() != 2);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        rdy_exp = 1'b0;
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outs("rst");
        rst_n = 1'b1;
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        in_ctrl = '0;
        in_data = '0;
        @(negedge clk);
        do_reset();

        // single entry
        step(1'b0, 8'h00, 32'h0, 1'b1, 1'b0);
        step(1'b1, 8'hB5, 32'h0000_1234, 1'b1, 1'b0);
        check("single_occ", 64'(occupancy), 64'd1);
        step(1'b0, 8'h00, 32'h0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 32'h0, 1'b1, 1'b0);

        // backpressure
        step(1'b1, 8'h01, 32'h11, 1'b0, 1'b0);
        step(1'b1, 8'h02, 32'h22, 1'b0, 1'b0);
        check("bp_occ", 64'(occupancy), 64'd2);
        check("bp_rdy", 64'(in_ready), 64'd0);
        check("bp_hold", 64'(out_ctrl), 64'h01);
        step(1'b1, 8'h03, 32'h33, 1'b0, 1'b0);
        check("bp_hold2", 64'(out_ctrl), 64'h01);
        step(1'b0, 8'h00, 32'h0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 32'h0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 32'h0, 1'b1, 1'b0);

        // streaming
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'(i + 8'h40), 32'(i), 1'b1, 1'b0);
        end
        step(1'b0, 8'h00, 32'h0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 32'h0, 1'b1, 1'b0);

        // flush while full with a new entry offered
        step(1'b1, 8'hA1, 32'hA1, 1'b0, 1'b0);
        step(1'b1, 8'hA2, 32'hA2, 1'b0, 1'b0);
        step(1'b1, 8'hA3, 32'hA3, 1'b1, 1'b1);
        check("fl_vld", 64'(out_valid), 64'd0);
        check("fl_rdy", 64'(in_ready), 64'd1);
        check("fl_occ", 64'(occupancy), 64'd0);
        repeat (3) step(1'b0, 8'h00, 32'h0, 1'b1, 1'b0);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom),
                 $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 19) == 0));
        end

        // async reset while full
        step(1'b0, 8'h00, 32'h0, 1'b1, 1'b1);
        step(1'b1, 8'hC1, 32'hC1, 1'b0, 1'b0);
        step(1'b1, 8'hC2, 32'hC2, 1'b0, 1'b0);
        check("mid_full", 64'(occupancy), 64'd2);
        #2 rst_n = 1'b0;
        #1 chk_reset_outs("mid");
        sb.delete();
        rdy_exp = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // perf: 5 stalls, 2 flushes of a non-empty stage
        step(1'b1, 8'h11, 32'h11, 1'b0, 1'b0);
        repeat (5) step(1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 32'h0, 1'b1, 1'b1);
        step(1'b1, 8'h22, 32'h22, 1'b1, 1'b0);
        step(1'b0, 8'h00, 32'h0, 1'b1, 1'b1);
`ifdef PIPELINE_STAGE_PERF_EN
        check("stall5", 64'(stall_cnt), 64'd5);
        check("flush2", 64'(flush_cnt), 64'd2);
        step(1'b1, 8'h33, 32'h33, 1'b0, 1'b0);
        in_valid = 1'b0;
        repeat (70000) @(negedge clk);
        check("stall_sat", 64'(stall_cnt), 64'hFFFF);
        check("sat_occ", 64'(occupancy), 64'd1);
`else
        check("stall_off", 64'(stall_cnt), 64'd0);
        check("flush_off", 64'(flush_cnt), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

endmodule

// File: doc/pipeline_stage_reg.md
PIPELINE_STAGE_REG -- requirements
Module: pipeline_stage_reg

Interface
REQ-001 SHALL have parameter CTRL_W, default 8, width of the control bundle {wbs, wme, mm, ALUop[1:0], wm, am, ni}.
REQ-002 SHALL have parameter DATA_W, default 32, width of the operand payload.
REQ-003 SHALL have parameter NOP_CTRL, default all-zero CTRL_W vector, the bubble control value.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port flush  input  1  synchronous discard of all held entries.
REQ-007 SHALL have port in_valid  input  1  upstream entry present.
REQ-008 SHALL have port in_ready  output  1  stage can accept an entry.
REQ-009 SHALL have port in_ctrl  input  CTRL_W  upstream control bundle.
REQ-010 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-011 SHALL have port out_valid  output  1  entry presented downstream.
REQ-012 SHALL have port out_ready  input  1  downstream accepts entry.
REQ-013 SHALL have port out_ctrl  output  CTRL_W  presented control bundle.
REQ-014 SHALL have port out_data  output  DATA_W  presented payload.
REQ-015 SHALL have port occupancy  output  2  entries held: 0, 1 or 2.
REQ-016 SHALL have ports stall_cnt and flush_cnt  output  16 each  performance counters (see Configuration).

Function
REQ-017 SHALL hold two entries, main and skid; outputs driven only from main register flops.
REQ-018 SHALL accept on in_valid && in_ready; SHALL retire on out_valid && out_ready.
REQ-019 SHALL drive in_ready from a flop: in_ready = 1 unless state is FULL.
REQ-020 SHALL implement states EMPTY, ONE, FULL: EMPTY->ONE on accept; ONE->FULL on accept without retire; ONE->EMPTY on retire without accept; ONE stays ONE on simultaneous accept and retire; FULL->ONE on retire (skid moves to main).
REQ-021 SHALL have latency 1 cycle: entry accepted at edge N appears on out_* after edge N when stage was EMPTY or retiring.
REQ-022 SHALL preserve order: skid entry always retires after main entry.
REQ-023 SHALL hold out_ctrl/out_data stable while out_valid && !out_ready.
REQ-024 SHALL drive out_ctrl = NOP_CTRL and out_data = 0 whenever out_valid = 0.
REQ-025 SHALL, on flush = 1, go to EMPTY next cycle, discarding main, skid and any entry accepted that cycle; flush has priority over accept and retire.
REQ-026 SHALL assert in_ready = 1 the cycle after flush.
REQ-027 SHALL reflect state in occupancy: EMPTY=0, ONE=1, FULL=2.

Reset
REQ-028 SHALL, while rst_n = 0, force state EMPTY, in_ready = 0, out_valid = 0, out_ctrl = NOP_CTRL, out_data = 0, occupancy = 0, counters = 0.
REQ-029 SHALL raise in_ready on the first rising clk edge after rst_n deasserts; reset mid-operation discards all entries.

Configuration
REQ-030 SHALL compile counters only with macro PIPELINE_STAGE_PERF_EN defined.
REQ-031 With PIPELINE_STAGE_PERF_EN: stall_cnt +1 each cycle out_valid && !out_ready; flush_cnt +1 each cycle flush = 1 and occupancy != 0; both saturate at 16'hFFFF.
REQ-032 Without PIPELINE_STAGE_PERF_EN: stall_cnt and flush_cnt SHALL be constant 0, no counter flops.

Structure
REQ-033 SHALL take from shared package pipe_pkg: packed struct ctrl_t (wbs, wme, mm, aluop[1:0], wm, am, ni), constant CTRL_W = 8, constant CTRL_NOP, state enum {EMPTY, ONE, FULL}.
REQ-034 SHALL instantiate sub-module sat_counter (16-bit, enable, synchronous increment, saturating, async active-low reset) twice for the counters.

Verification
REQ-035 Reset then single entry: in_ctrl=8'hB5, in_data=32'h0000_1234, out_ready=1 -> out_valid=1 with same values 1 cycle later, occupancy=1, then 0.
REQ-036 Backpressure: out_ready=0, push 8'h01, 8'h02 -> occupancy=2, in_ready=0, out_ctrl held 8'h01; release out_ready -> 8'h01 then 8'h02, in order.
REQ-037 Streaming: in_valid=1, out_ready=1 for 10 cycles, data 0..9 -> out_data 0..9 one per cycle, occupancy=1 throughout, no gaps.
REQ-038 Flush while FULL with in_valid=1: next cycle out_valid=0, out_ctrl=NOP_CTRL, out_data=0, occupancy=0, in_ready=1; flushed values never appear.
REQ-039 Reset mid-operation: rst_n=0 while FULL -> all outputs at reset values immediately, without clock edge.
REQ-040 With PIPELINE_STAGE_PERF_EN: 5 stalled cycles, 2 flushes of non-empty stage -> stall_cnt=5, flush_cnt=2; 70000 stalled cycles -> stall_cnt=16'hFFFF.
